dot_operand_loader: RTL and testbench
=====================================

// Module: dot_operand_loader
// PURPOSE
// - Upstream feeder for the 16-element matrix_dot unit: collects a byte stream (16 A bytes, then 16 B bytes)
//   into operand registers, clears and starts the dot unit, waits for completion, returns the 16-bit result.
// - Sits between the NPU input DMA/byte stream and matrix_dot; owns the dot unit's per-frame clear and start.
// PARAMETERS
// - N               16    elements per vector; fixed at 16 to match matrix_dot (other values unsupported)
// - TIMEOUT_CYCLES  8192  watchdog limit in WAIT state (only used with DOT_LOADER_TIMEOUT_EN)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      stream byte valid
// - in_data    in   8      stream byte (unsigned)
// - in_ready   out  1      loader accepts byte this cycle
// - dot_a      out  8x16   operand A array [0:15] to matrix_dot a
// - dot_b      out  8x16   operand B array [0:15] to matrix_dot b
// - dot_clr_n  out  1      drives matrix_dot rst_n; low = clear dot unit
// - dot_start  out  1      one-cycle start pulse to matrix_dot
// - dot_c      in   16     matrix_dot result c
// - dot_done   in   1      matrix_dot done (sticky until its reset)
// - res_valid  out  1      result available
// - res_data   out  16     captured dot result
// - res_err    out  1      result invalid (timeout)
// - res_ready  in   1      consumer accepts result
// BEHAVIOUR
// - Reset (rst=1 at edge): state=LOAD, byte_cnt=0, dot_a/dot_b all 0, dot_clr_n=0, dot_start=0,
//   res_valid=0, res_data=0, res_err=0, watchdog=0. Reset mid-frame discards everything; no partial result.
// - FSM: LOAD -> CLR -> START -> WAIT -> RESULT -> LOAD.
// - LOAD: in_ready=1 (combinational from state). Byte accepted when in_valid&in_ready; byte k (0..15) -> dot_a[k],
//   byte k (16..31) -> dot_b[k-16]. byte_cnt 5 bits, wraps 31->0 on acceptance of byte 31, FSM -> CLR same edge.
//   in_valid gaps allowed; no byte lost or duplicated.
// - CLR: dot_clr_n=0 for exactly one cycle (needed: dot_done is sticky); -> START.
// - START: dot_clr_n=1, dot_start=1 for exactly one cycle; -> WAIT.
// - WAIT: dot_start=0; on first cycle with dot_done=1: res_data<=dot_c, res_err<=0, res_valid<=1, -> RESULT.
// - RESULT: res_valid/res_data/res_err held stable until res_valid&res_ready; then res_valid<=0, -> LOAD;
//   in_ready rises the cycle after the handshake (no byte accepted in the handshake cycle).
// - dot_a/dot_b written only in LOAD; stable from CLR through RESULT.
// - dot_clr_n is 1 in every state except CLR and reset; dot_start is 1 only in START.
// - Latency: last byte accepted at edge T -> dot_clr_n low in cycle T+1, dot_start high in T+2, WAIT from T+3;
//   res_valid rises the edge after dot_done first seen high in WAIT.
// - All arithmetic unsigned; dot_c captured verbatim, no truncation or saturation.
// CONFIGURATION
// - DOT_LOADER_TIMEOUT_EN defined: watchdog counts WAIT cycles from 0; if count reaches TIMEOUT_CYCLES-1
//   with dot_done still 0: res_data<=0, res_err<=1, res_valid<=1, -> RESULT. Done and timeout in same
//   cycle: done wins (res_err=0). Watchdog cleared on entry to WAIT.
// - Not defined: no watchdog logic; WAIT waits indefinitely; res_err tied 0.
// TESTING (bench drives a behavioural dot model: done K cycles after start, c = sum a[i]*b[i] mod 2^16)
// - Reset: hold rst 3 cycles -> in_ready=1, dot_clr_n=0 during rst, res_valid=0, dot_a/dot_b all 0, dot_start=0.
// - Frame a=1..16, b=all 2, K=20, res_ready=1 -> one dot_clr_n low cycle, then one dot_start pulse,
//   res_valid with res_data=272, res_err=0; exactly one result per frame.
// - Random in_valid gaps during load + res_ready low 10 cycles -> operands exact, res_data/res_valid held,
//   in_ready=0 until handshake, then 1 next cycle.
// - DOT_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=64, model never asserts done -> res_valid after 64 WAIT cycles,
//   res_err=1, res_data=0; next frame with K=5 returns correct result (clr clears stale state).
// - Reset asserted in WAIT and in RESULT -> back to LOAD, no res_valid, next full frame gives correct result.
// - Two back-to-back frames (a=all 255,b=all 255 -> 16*65025 mod 2^16 = 57360; then a=0,b=all 7 -> 0),
//   second frame's dot_done seen only after its own clear -> results 57360 then 0, in order.

Source files
------------

// File: rtl/dot_operand_loader.sv
// Byte-stream feeder for matrix_dot: loads A/B operands, clears and starts the dot unit, returns its result.
// Optional WAIT-state watchdog is compiled in with `define DOT_LOADER_TIMEOUT_EN.
//
//   state    | meaning
//   S_LOAD   | accept 32 stream bytes (16 A, then 16 B)
//   S_CLR    | hold dot unit in reset for one cycle to drop its sticky done
//   S_START  | one-cycle start pulse to the dot unit
//   S_WAIT   | wait for dot_done (or watchdog expiry)
//   S_RESULT | present result until the consumer takes it
module dot_operand_loader #(
    parameter int N = 16
`ifdef DOT_LOADER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 8192
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic [7:0]  o_dot_a [0:N-1],
    output logic [7:0]  o_dot_b [0:N-1],
    output logic        o_dot_clr_n,
    output logic        o_dot_start,
    input  logic [15:0] i_dot_c,
    input  logic        i_dot_done,
    output logic        o_res_valid,
    output logic [15:0] o_res_data,
    output logic        o_res_err,
    input  logic        i_res_ready
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLR,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_byte_cnt;
    logic [7:0]  r_dot_a [0:N-1];
    logic [7:0]  r_dot_b [0:N-1];
    logic        r_res_valid;
    logic [15:0] r_res_data;
    logic        w_accept;
    logic        w_timeout;

`ifdef DOT_LOADER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    logic [WDW-1:0] r_wdog;
    logic           r_res_err;

    assign w_timeout = (r_wdog == WDW'(TIMEOUT_CYCLES - 1));
    assign o_res_err = r_res_err;
`else
    assign w_timeout = 1'b0;
    assign o_res_err = 1'b0;
`endif

    assign w_accept    = i_in_valid && o_in_ready;
    assign o_in_ready  = (r_state == S_LOAD);
    // Gated by rst directly so the dot unit is held cleared for the whole reset window.
    assign o_dot_clr_n = (r_state != S_CLR) && !i_rst;
    assign o_dot_start = (r_state == S_START);
    assign o_dot_a     = r_dot_a;
    assign o_dot_b     = r_dot_b;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:   if (w_accept && (r_byte_cnt == 5'd31)) w_next = S_CLR;
            S_CLR:    w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT:   if (i_dot_done || w_timeout) w_next = S_RESULT;
            S_RESULT: if (i_res_ready) w_next = S_LOAD;
            default:  w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_LOAD;
            r_byte_cnt  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            for (int i = 0; i < N; i++) begin
                r_dot_a[i] <= '0;
                r_dot_b[i] <= '0;
            end
`ifdef DOT_LOADER_TIMEOUT_EN
            r_wdog    <= '0;
            r_res_err <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (!r_byte_cnt[4]) r_dot_a[r_byte_cnt[3:0]] <= i_in_data;
                        else                r_dot_b[r_byte_cnt[3:0]] <= i_in_data;
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                    end
                end
                S_START: begin
`ifdef DOT_LOADER_TIMEOUT_EN
                    r_wdog <= '0;
`endif
                end
                S_WAIT: begin
                    // Done takes priority over a simultaneous watchdog expiry.
                    if (i_dot_done) begin
                        r_res_data  <= i_dot_c;
                        r_res_valid <= 1'b1;
`ifdef DOT_LOADER_TIMEOUT_EN
                        r_res_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
`endif
                    end
                end
                S_RESULT: begin
                    if (i_res_ready) r_res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_operand_loader.sv
// Randomized bench for dot_operand_loader with a behavioural matrix_dot stand-in.
// Build with DOT_LOADER_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYCLES=64).
module tb_dot_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [7:0]  dot_a [0:15];
    logic [7:0]  dot_b [0:15];
    logic        dot_clr_n;
    logic        dot_start;
    logic [15:0] dot_c;
    logic        dot_done;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_err;
    logic        res_ready = 1'b0;

    int n_vec = 0;
    int n_miss = 0;
    int n_results = 0;
    int n_expected_results = 0;

    logic [7:0] fa [16];
    logic [7:0] fb [16];

    // dot unit model state
    int          dot_k = 5;
    bit          dot_never = 1'b0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_c = '0;

    always #5 clk = ~clk;

    dot_operand_loader #(
        .N(16)
`ifdef DOT_LOADER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_dot_a     (dot_a),
        .o_dot_b     (dot_b),
        .o_dot_clr_n (dot_clr_n),
        .o_dot_start (dot_start),
        .i_dot_c     (dot_c),
        .i_dot_done  (dot_done),
        .o_res_valid (res_valid),
        .o_res_data  (res_data),
        .o_res_err   (res_err),
        .i_res_ready (res_ready)
    );

    assign dot_c    = m_c;
    assign dot_done = m_done;

    function automatic logic [15:0] unit_dot();
        int unsigned s = 0;
        for (int i = 0; i < 16; i++) s += int'(dot_a[i]) * int'(dot_b[i]);
        return 16'(s);
    endfunction

    // matrix_dot stand-in: done goes high dot_k edges after the start edge, sticky until clear
    always @(posedge clk) begin
        if (!dot_clr_n) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_c    <= '0;
        end else if (dot_start) begin
            m_cnt <= dot_never ? 0 : dot_k;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_c    <= unit_dot();
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && res_valid && res_ready) n_results++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_dot();
        int unsigned s = 0;
        for (int i = 0; i < 16; i++) s += int'(fa[i]) * int'(fb[i]);
        return 16'(s % 65536);
    endfunction

    task automatic load_frame(input int gap_pct);
        int k = 0;
        int budget = 0;
        int bad = 0;
        while (k < 32 && budget < 2000) begin
            @(negedge clk);
            budget++;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = (k < 16) ? fa[k] : fb[k-16];
            end
            if (in_valid && in_ready) k++;
        end
        chk("load_bytes", k, 32);
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_low", {dot_clr_n, dot_start, in_ready}, 3'b000);
        for (int i = 0; i < 16; i++) begin
            if (dot_a[i] !== fa[i]) bad++;
            if (dot_b[i] !== fb[i]) bad++;
        end
        chk("operands", bad, 0);
        @(negedge clk);
        chk("start_pulse", {dot_clr_n, dot_start}, 2'b11);
        @(negedge clk);
        chk("start_end", {dot_clr_n, dot_start}, 2'b10);
    endtask

    task automatic wait_result(input int exp_wait);
        int n = 0;
        while (!res_valid && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_wait);
    endtask

    task automatic finish_frame(input logic [15:0] exp_data, input logic exp_err,
                                input int exp_wait, input int hold);
        int bad = 0;
        wait_result(exp_wait);
        chk("res_data", res_data, exp_data);
        chk("res_err", res_err, exp_err);
        repeat (hold) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== exp_data || res_err !== exp_err || in_ready !== 1'b0)
                bad++;
        end
        chk("hold", bad, 0);
        res_ready = 1'b1;
        chk("hs_in_ready", in_ready, 0);
        n_expected_results++;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_hs", {res_valid, in_ready}, 2'b01);
    endtask

    task automatic run_frame(input int k, input int gap_pct, input int hold);
        dot_k = k;
        dot_never = 1'b0;
        load_frame(gap_pct);
        finish_frame(ref_dot(), 1'b0, k + 1, hold);
    endtask

    task automatic rand_operands();
        for (int i = 0; i < 16; i++) begin
            fa[i] = 8'($urandom);
            fb[i] = 8'($urandom);
        end
    endtask

    task automatic pulse_reset_and_idle(input string tag, input int idle);
        int bad = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk({tag, "_rst"}, {in_ready, res_valid, dot_clr_n, dot_start}, 4'b1000);
        rst = 1'b0;
        repeat (idle) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk({tag, "_no_partial"}, bad, 0);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {in_ready, dot_clr_n, res_valid, dot_start, res_err}, 5'b10000);
        chk("rst_res_data", res_data, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (dot_a[i] !== 8'd0 || dot_b[i] !== 8'd0) bad++;
        chk("rst_operands", bad, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", {in_ready, dot_clr_n}, 2'b11);

        // a = 1..16, b = 2 -> 272
        for (int i = 0; i < 16; i++) begin
            fa[i] = 8'(i + 1);
            fb[i] = 8'd2;
        end
        chk("ref_272", ref_dot(), 16'd272);
        run_frame(20, 0, 0);

        // gaps on the stream, consumer stalls 10 cycles
        rand_operands();
        run_frame(7, 50, 10);

        for (int f = 0; f < 6; f++) begin
            rand_operands();
            run_frame($urandom_range(1, 30), $urandom_range(0, 60), $urandom_range(0, 12));
        end

`ifdef DOT_LOADER_TIMEOUT_EN
        rand_operands();
        dot_never = 1'b1;
        load_frame(20);
        finish_frame(16'd0, 1'b1, 64, 3);
        rand_operands();
        run_frame(5, 20, 2);
`endif

        // reset while waiting on the dot unit
        rand_operands();
        dot_k = 40;
        dot_never = 1'b0;
        load_frame(10);
        repeat (5) @(negedge clk);
        pulse_reset_and_idle("rst_wait", 60);
        rand_operands();
        run_frame(9, 30, 1);

        // reset while a result is pending
        rand_operands();
        dot_k = 3;
        load_frame(10);
        wait_result(4);
        repeat (2) @(negedge clk);
        pulse_reset_and_idle("rst_result", 20);
        rand_operands();
        run_frame(6, 30, 0);

        // back-to-back frames: 57360 then 0
        for (int i = 0; i < 16; i++) begin
            fa[i] = 8'd255;
            fb[i] = 8'd255;
        end
        chk("ref_57360", ref_dot(), 16'd57360);
        run_frame(4, 0, 0);
        for (int i = 0; i < 16; i++) begin
            fa[i] = 8'd0;
            fb[i] = 8'd7;
        end
        run_frame(4, 0, 0);

        @(negedge clk);
        chk("result_count", n_results, n_expected_results);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
